// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage memory access unit: access sizes, FSM states,
// and the request legality check.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Flags misaligned halves/words, the reserved size and out-of-range addresses.
  function automatic logic req_err(input logic [1:0]  size,
                                   input logic [31:0] addr,
                                   input logic [31:0] mem_bytes);
    logic e;
    e = (addr >= mem_bytes);
    case (size)
      SIZE_BYTE: e = e;
      SIZE_HALF: e = e | addr[0];
      SIZE_WORD: e = e | (|addr[1:0]);
      default:   e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response channel plus word-memory port of the MEM-stage access unit.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
           mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
           mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/mem_access_unit_byte_lane_align.sv
// Little-endian lane steering: merges sub-word store data into an old word and
// extracts/extends sub-word load data from a fetched word.
module byte_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [31:0] shifted;

  always_comb begin
    merged = wdata;
    case (size)
      SIZE_BYTE: begin
        merged = old_word;
        merged[offset*8 +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        merged = old_word;
        merged[offset[1]*16 +: 16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  always_comb begin
    shifted   = rd_word >> {offset, 3'b000};
    extracted = rd_word;
    case (size)
      SIZE_BYTE: extracted = {{24{is_signed & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: extracted = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default:   extracted = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns lb/lh/lw/sb/sh/sw into word-only memory cycles,
// using read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        signed_q, signed_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        err_now;
  logic [31:0] merged;
  logic [31:0] extracted;

  assign accept  = bus.req_valid && (state_q == ST_IDLE);
  assign err_now = req_err(bus.req_size, bus.req_addr, 32'(MEM_BYTES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        if (err_now)                                     state_d = ST_RESP;
        else if (bus.req_we && bus.req_size == SIZE_WORD) state_d = ST_WR;
        else                                             state_d = ST_RD;
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Enables decode straight from the state so reset drops them asynchronously.
  always_comb begin
    bus.req_ready   = (state_q == ST_IDLE);
    bus.mem_rd_en   = (state_q == ST_RD);
    bus.mem_wr_en   = (state_q == ST_WR);
    bus.mem_addr    = {addr_q[31:2], 2'b00};
    bus.mem_wr_data = (state_q == ST_WR) ? merged : 32'h0;
    bus.resp_valid  = resp_valid_q;
    bus.resp_rdata  = resp_rdata_q;
    bus.resp_err    = resp_err_q;
  end

  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    we_d         = we_q;
    signed_d     = signed_q;
    word_d       = word_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      addr_d   = bus.req_addr;
      wdata_d  = bus.req_wdata;
      size_d   = bus.req_size;
      we_d     = bus.req_we;
      signed_d = bus.req_signed;
    end
    case (state_q)
      ST_IDLE: if (accept && err_now) begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b1;
      end
      ST_RD: begin
        word_d = bus.mem_rd_data;
        if (!we_q) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = extracted;
          resp_err_d   = 1'b0;
        end
      end
      ST_WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
      ST_RESP: if (bus.resp_ready) resp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      we_q         <= we_d;
      signed_q     <= signed_d;
      word_q       <= word_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  byte_lane_align u_align (
    .old_word  (word_q),
    .wdata     (wdata_q),
    .rd_word   (bus.mem_rd_data),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .is_signed (signed_q),
    .merged    (merged),
    .extracted (extracted)
  );

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipeline-side initiator for the word-organised data memory in the multicycle MIPS datapath. It sits in the MEM stage between the pipeline's load/store request and the data memory's rd_en/wr_en/addr/wr_data/rd_data port. It turns byte, halfword and word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) into word-only memory cycles, using read-modify-write for sub-word stores. It returns sign- or zero-extended load data through a valid/ready response channel.

## Interface
Parameters:
- MEM_BYTES, 128: addressable bytes. Any address ≥ MEM_BYTES is an error.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out of range, or reserved size
- mem_addr  out  32  byte address to memory; bits [1:0] always 00
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_wr_data  out  32  full word to write
- mem_rd_data  in  32  memory read data, combinational in mem_addr while mem_rd_en is high

## Operation
- Byte lanes are little-endian: byte offset 0 is bits [7:0], offset 3 is bits [31:24].
- Handshake: a transfer occurs on a clock edge where valid and ready are both high. The unit latches addr, size, we, signed and wdata on acceptance.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE → RESP when the request is in error. No memory enable is asserted.
  - IDLE → RD for a load or a sub-word store.
  - IDLE → WR for a word store.
  - RD → RESP for a load.
  - RD → WR for a sub-word store.
  - WR → RESP.
  - RESP → IDLE when resp_ready is high.
- Error conditions:
  - half at an odd address
  - word with addr[1:0] ≠ 0
  - size 11
  - addr ≥ MEM_BYTES
- RD: mem_rd_en = 1. The word is captured into an internal register at the closing edge.
- WR: mem_wr_en = 1. mem_wr_data is either the captured word with the target lane(s) replaced by req_wdata[7:0] or [15:0], or req_wdata unchanged for sw.
- Load extract: select the lane by addr[1:0]. Extend from bit 7 (byte) or bit 15 (half) when signed, otherwise fill with zeros. Word loads pass through.
- mem_rd_en and mem_wr_en are decoded from the state and are never high together. mem_addr = {latched_addr[31:2], 2'b00}. It is held stable through RD and WR.
- resp_* are registered and held unchanged while resp_valid && !resp_ready.
- Asserting reset mid-operation aborts immediately. Any in-flight write is dropped, because mem_wr_en falls asynchronously.

## Timing
- Reset values:
  - state IDLE, req_ready 1
  - resp_valid 0, resp_rdata 0, resp_err 0
  - mem_rd_en 0, mem_wr_en 0
  - mem_addr 0, mem_wr_data 0
- Latency from acceptance edge to the first cycle with resp_valid high:
  - lw/lh/lb, and sw: 2 cycles
  - sh/sb: 3 cycles
  - error: 1 cycle
- Throughput: a new request can be accepted in the cycle after the response handshake, because req_ready is low during RESP.
- Back-to-back: a store followed by a load to the same word returns the stored data, since the memory write commits at the WR edge.

## Structure
- Package mem_access_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams
  - the state encoding
  - a function returning the misalignment/error flag
- Sub-module byte_lane_align (combinational) provides:
  - a store-merge path: old word, wdata, size, offset → merged word
  - a load-extract path: word, size, offset, signed → result
- The top level holds the FSM, the request latch and the response registers.

## Test plan
The bench memory model preloads word 0 = 0x02328021 and word 7 = 0x0000000A.
- lb addr 0x01, signed → rdata 0xFFFFFF80. lbu same address → 0x00000080. One mem_rd_en pulse each, resp at +2.
- lh addr 0x00, signed → 0xFFFF8021. lhu addr 0x02 → 0x00000232. lw addr 0x1C → 0x0000000A.
- sb addr 0x1D, wdata 0x123456AB → RD then WR. mem_wr_data 0x0000AB0A. A following lw 0x1C returns 0x0000AB0A. resp at +3.
- sw addr 0x06 → resp_err 1 at +1, mem_rd_en and mem_wr_en never high. lw addr 0x80 → resp_err 1. req_size 11 → resp_err 1.
- Hold resp_ready low 3 cycles after an lw → resp_valid and resp_rdata stable, req_ready 0. Release → IDLE next cycle, req_ready 1.
- Assert reset during the WR state of an sh → mem_wr_en 0 immediately, all outputs at reset values, memory word unchanged.
